// File: rtl/cla_pkg.sv
// Shared types and helpers for the iterative carry-lookahead add/sub unit.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int GROUP_DEF = 4;

  // Slice counter width; a single-slice datapath still needs one bit.
  function automatic int cnt_w(input int ngrp);
    return (ngrp > 1) ? $clog2(ngrp) : 1;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             t;
  logic             pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate terms gated by propagate chains.
  always_comb begin
    c    = '0;
    t    = 1'b0;
    pp   = 1'b1;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      t  = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        t  = t | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & cin);
    end
  end

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];

endmodule

// File: rtl/cla_addsub_seq.sv
// Iterative add/subtract: one lookahead slice per cycle, carry registered
// between slices, valid/ready on both sides with carry/overflow/zero flags.
module cla_addsub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int CW   = cnt_w(NGRP);

  state_e           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [GROUP-1:0] ga, gb, gs;
  logic             gc;
  logic [WIDTH-1:0] sh_w;

  assign ga = a_q[int'(k_q)*GROUP +: GROUP];
  assign gb = bx_q[int'(k_q)*GROUP +: GROUP];

  cla_group #(
    .GROUP(GROUP)
  ) u_grp (
    .a   (ga),
    .b   (gb),
    .cin (carry_q),
    .sum (gs),
    .cout(gc)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    bx_d     = bx_q;
    sh_d     = sh_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    sh_w     = sh_q;
    sh_w[int'(k_q)*GROUP +: GROUP] = gs;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bx_d    = sub ? ~b : b;
          carry_d = sub ? ~c_in : c_in;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d    = sh_w;
        carry_d = gc;
        k_d     = k_q + 1'b1;
        // Visible outputs only move once the top slice lands.
        if (k_q == CW'(NGRP-1)) begin
          k_d      = '0;
          state_d  = DONE;
          result_d = sh_w;
          c_out_d  = gc;
          ovf_d    = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                     (sh_w[WIDTH-1] != a_q[WIDTH-1]);
          zero_d   = (sh_w == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      sh_q     <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
